// File: rtl/gshare_pht.sv
// gshare pattern history table with an in-order queue of in-flight predictions.
// The table index is index_i XOR the speculative global history register.
// Each entry holds an N-bit saturating counter and a valid bit.
// Optional feature macro: GSHARE_PHT_BYPASS_EN. When it is defined, a lookup
// that hits the entry being resolved in the same cycle sees the post-update counter.
module gshare_pht #(
    parameter int INDEX_WIDTH = 6,
    parameter int CTR_WIDTH   = 2,
    parameter int HIST_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic                           lookup_valid_i,
    output logic                           lookup_ready_o,
    input  logic [INDEX_WIDTH-1:0]         index_i,
    input  logic                           fallback_i,
    output logic                           taken_o,
    input  logic                           resolve_valid_i,
    input  logic                           resolve_taken_i,
    input  logic                           flush_i,
    output logic                           mispredict_o,
    output logic [HIST_WIDTH-1:0]          ghr_o,
    output logic [$clog2(QUEUE_DEPTH):0]   count_o
);

    localparam int SIZE  = 1 << INDEX_WIDTH;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    // Weak-taken is the smallest value with the MSB set; weak-not-taken is one below it.
    localparam logic [CTR_WIDTH-1:0] WEAK_T  = CTR_ONE << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] WEAK_NT = WEAK_T - CTR_ONE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_WIDTH-1:0]   ctr_reg    [SIZE];
    logic [CTR_WIDTH-1:0]   ctr_next   [SIZE];
    logic                   valid_reg  [SIZE];
    logic                   valid_next [SIZE];

    // Queue payload: hashed index, the prediction made, and the GHR at lookup time.
    logic [INDEX_WIDTH-1:0] q_idx_reg  [QUEUE_DEPTH];
    logic [HIST_WIDTH-1:0]  q_snap_reg [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_pred_reg;

    logic [PTR_W-1:0]       head_reg, head_next;
    logic [PTR_W-1:0]       tail_reg, tail_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [HIST_WIDTH-1:0]  ghr_reg, ghr_next;
    logic                   mispredict_reg;

    // ------------------------------------------------------------------
    // Lookup side
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [INDEX_WIDTH-1:0] hidx;
    logic                   hit;
    logic [CTR_WIDTH-1:0]   rd_ctr;

    // The GHR is zero-extended so it only folds into the low index bits.
    assign ghr_ext = INDEX_WIDTH'(ghr_reg);
    assign hidx    = index_i ^ ghr_ext;
    assign hit     = valid_reg[hidx];
    assign rd_ctr  = ctr_reg[hidx];

    // ------------------------------------------------------------------
    // Resolve side (always refers to the oldest queued entry)
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] head_idx;
    logic                   head_pred;
    logic [HIST_WIDTH-1:0]  head_snap;
    logic [CTR_WIDTH-1:0]   head_ctr;
    logic [CTR_WIDTH-1:0]   res_ctr;
    logic                   queue_empty;
    logic                   resolve_acc;
    logic                   mispredict;
    logic                   squash;
    logic                   lookup_acc;
    logic                   alloc;

    assign head_idx    = q_idx_reg[head_reg];
    assign head_pred   = q_pred_reg[head_reg];
    assign head_snap   = q_snap_reg[head_reg];
    assign head_ctr    = ctr_reg[head_idx];

    assign queue_empty    = (count_reg == '0);
    assign lookup_ready_o = (count_reg < CNT_W'(QUEUE_DEPTH));

    // A resolve against an empty queue is dropped silently.
    assign resolve_acc = en_i & resolve_valid_i & ~queue_empty;
    assign mispredict  = resolve_acc & (resolve_taken_i ^ head_pred);
    assign squash      = mispredict | (en_i & flush_i);

    // Saturating increment/decrement of the head entry's counter.
    always_comb begin
        res_ctr = head_ctr;
        if (resolve_taken_i) begin
            if (head_ctr != CTR_MAX) begin
                res_ctr = head_ctr + CTR_ONE;
            end
        end else begin
            if (head_ctr != '0) begin
                res_ctr = head_ctr - CTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prediction
    // ------------------------------------------------------------------
`ifdef GSHARE_PHT_BYPASS_EN
    logic bypass_hit;

    // Only a correct resolve can forward; a mispredict discards the lookup anyway.
    assign bypass_hit = resolve_acc & ~mispredict & (head_idx == hidx) & hit;
    assign taken_o    = bypass_hit ? res_ctr[CTR_WIDTH-1]
                      : (hit ? rd_ctr[CTR_WIDTH-1] : fallback_i);
`else
    assign taken_o    = hit ? rd_ctr[CTR_WIDTH-1] : fallback_i;
`endif

    assign lookup_acc = en_i & lookup_valid_i & lookup_ready_o & ~squash;
    assign alloc      = lookup_acc & ~hit;

    // ------------------------------------------------------------------
    // History shifting (a 1-bit history has no older bits to keep)
    // ------------------------------------------------------------------
    logic [HIST_WIDTH-1:0] ghr_spec;
    logic [HIST_WIDTH-1:0] ghr_repair;

    generate
        if (HIST_WIDTH == 1) begin : g_hist_one
            assign ghr_spec   = taken_o;
            assign ghr_repair = resolve_taken_i;
        end else begin : g_hist_many
            assign ghr_spec   = {ghr_reg[HIST_WIDTH-2:0], taken_o};
            assign ghr_repair = {head_snap[HIST_WIDTH-2:0], resolve_taken_i};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-entry next state: resolve update takes priority over allocation
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_entry
            logic res_sel;
            logic alloc_sel;

            assign res_sel         = resolve_acc & (head_idx == INDEX_WIDTH'(gi));
            assign alloc_sel       = alloc & (hidx == INDEX_WIDTH'(gi));
            assign ctr_next[gi]    = res_sel   ? res_ctr
                                   : alloc_sel ? (fallback_i ? WEAK_T : WEAK_NT)
                                   : ctr_reg[gi];
            assign valid_next[gi]  = valid_reg[gi] | alloc_sel;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Queue pointer and history next state
    // ------------------------------------------------------------------
    always_comb begin
        head_next = head_reg + PTR_W'(resolve_acc);
        if (squash) begin
            // Emptying the queue means tail catches up with head.
            tail_next  = head_next;
            count_next = '0;
        end else begin
            tail_next  = tail_reg + PTR_W'(lookup_acc);
            count_next = count_reg + CNT_W'(lookup_acc) - CNT_W'(resolve_acc);
        end

        if (mispredict) begin
            ghr_next = ghr_repair;
        end else if (lookup_acc) begin
            ghr_next = ghr_spec;
        end else begin
            ghr_next = ghr_reg;
        end
    end

    // Table counters and valid bits; reset clears every entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SIZE; i++) begin
                ctr_reg[i]   <= '0;
                valid_reg[i] <= 1'b0;
            end
        end else begin
            ctr_reg   <= ctr_next;
            valid_reg <= valid_next;
        end
    end

    // Queue payload is written at the tail on an accepted lookup; no reset needed.
    always_ff @(posedge clk_i) begin
        if (rst_ni && lookup_acc) begin
            q_idx_reg[tail_reg]  <= hidx;
            q_pred_reg[tail_reg] <= taken_o;
            q_snap_reg[tail_reg] <= ghr_reg;
        end
    end

    // Pointers, occupancy, speculative history and the mispredict pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            ghr_reg        <= '0;
            mispredict_reg <= 1'b0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            ghr_reg        <= ghr_next;
            mispredict_reg <= mispredict;
        end
    end

    assign mispredict_o = mispredict_reg;
    assign ghr_o        = ghr_reg;
    assign count_o      = count_reg;

endmodule

// File: tb/tb_gshare_pht.sv
// Testbench for gshare_pht: directed plus random stimulus, expected outputs from
// a queue/array reference model, compared by an independent negedge monitor.
module tb_gshare_pht;

    localparam int IW   = 6;
    localparam int CW   = 2;
    localparam int HW   = 4;
    localparam int QD   = 4;
    localparam int SIZE = 1 << IW;
    localparam int CNTW = $clog2(QD) + 1;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            en_i;
    logic            lookup_valid_i;
    logic            lookup_ready_o;
    logic [IW-1:0]   index_i;
    logic            fallback_i;
    logic            taken_o;
    logic            resolve_valid_i;
    logic            resolve_taken_i;
    logic            flush_i;
    logic            mispredict_o;
    logic [HW-1:0]   ghr_o;
    logic [CNTW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    gshare_pht #(
        .INDEX_WIDTH (IW),
        .CTR_WIDTH   (CW),
        .HIST_WIDTH  (HW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .en_i            (en_i),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_ready_o  (lookup_ready_o),
        .index_i         (index_i),
        .fallback_i      (fallback_i),
        .taken_o         (taken_o),
        .resolve_valid_i (resolve_valid_i),
        .resolve_taken_i (resolve_taken_i),
        .flush_i         (flush_i),
        .mispredict_o    (mispredict_o),
        .ghr_o           (ghr_o),
        .count_o         (count_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int hidx;
        bit pred;
        int snap;
    } ent_t;

    typedef struct {
        bit taken;
        bit ready;
        int ghr;
        int count;
        bit misp;
        int cyc;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   m_ctr   [SIZE];
    bit   m_valid [SIZE];
    int   m_ghr;
    bit   m_misp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic void model_reset();
        for (int i = 0; i < SIZE; i++) begin
            m_ctr[i]   = 0;
            m_valid[i] = 1'b0;
        end
        mq.delete();
        m_ghr  = 0;
        m_misp = 1'b0;
    endfunction

    // One clock cycle: drive inputs, record what the DUT must show this cycle,
    // then advance the model to the state after the coming edge.
    task automatic step(input bit rst, input bit en, input bit lv, input int idx,
                        input bit fb, input bit rv, input bit rt, input bit fl);
        int   half, maxc, mask, h, newc, hh;
        bit   hit, pred, ready, racc, misp, sq, lacc;
        exp_t e;
        ent_t ne;

        rst_ni          = rst;
        en_i            = en;
        lookup_valid_i  = lv;
        index_i         = idx[IW-1:0];
        fallback_i      = fb;
        resolve_valid_i = rv;
        resolve_taken_i = rt;
        flush_i         = fl;

        half  = 1 << (CW - 1);
        maxc  = (1 << CW) - 1;
        mask  = (1 << HW) - 1;
        h     = (idx ^ m_ghr) % SIZE;
        hit   = m_valid[h];
        pred  = hit ? (m_ctr[h] >= half) : fb;
        ready = (mq.size() < QD);
        racc  = en && rv && (mq.size() > 0);
        misp  = racc && (rt != mq[0].pred);
        newc  = 0;
        hh    = 0;
        if (racc) begin
            hh   = mq[0].hidx;
            newc = rt ? ((m_ctr[hh] < maxc) ? m_ctr[hh] + 1 : maxc)
                      : ((m_ctr[hh] > 0) ? m_ctr[hh] - 1 : 0);
        end
`ifdef GSHARE_PHT_BYPASS_EN
        if (racc && !misp && hh == h && hit) pred = (newc >= half);
`endif
        e.taken = pred;
        e.ready = ready;
        e.ghr   = m_ghr;
        e.count = mq.size();
        e.misp  = m_misp;
        e.cyc   = cyc;
        sb.push_back(e);

        sq   = misp || (en && fl);
        lacc = en && lv && ready && !sq;

        if (!rst) begin
            model_reset();
        end else begin
            ne.hidx = h;
            ne.pred = pred;
            ne.snap = m_ghr;
            if (lacc && !hit) begin
                m_ctr[h]   = fb ? half : half - 1;
                m_valid[h] = 1'b1;
            end
            if (racc) m_ctr[hh] = newc;
            if (misp) m_ghr = ((mq[0].snap << 1) | int'(rt)) & mask;
            else if (lacc) m_ghr = ((m_ghr << 1) | int'(pred)) & mask;
            if (racc) void'(mq.pop_front());
            if (lacc) mq.push_back(ne);
            if (sq) mq.delete();
            m_misp = misp;
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Shorthand for an enabled, non-reset cycle.
    task automatic go(input bit lv, input int idx, input bit fb,
                      input bit rv, input bit rt, input bit fl);
        step(1'b1, 1'b1, lv, idx, fb, rv, rt, fl);
    endtask

    function automatic bit head_pred();
        return (mq.size() > 0) ? mq[0].pred : 1'b0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    function automatic void chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cyc %0d %s: got %0h expected %0h", c, nm, act, exp);
        end
    endfunction

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("taken_o",        e.cyc, 32'(taken_o),        32'(e.taken));
            chk("lookup_ready_o", e.cyc, 32'(lookup_ready_o), 32'(e.ready));
            chk("ghr_o",          e.cyc, 32'(ghr_o),          32'(e.ghr));
            chk("count_o",        e.cyc, 32'(count_o),        32'(e.count));
            chk("mispredict_o",   e.cyc, 32'(mispredict_o),   32'(e.misp));
            $display("cyc %0d lv=%0b idx=%0d rv=%0b rt=%0b fl=%0b taken=%0b ready=%0b ghr=%0h count=%0d misp=%0b",
                     e.cyc, lookup_valid_i, index_i, resolve_valid_i, resolve_taken_i,
                     flush_i, taken_o, lookup_ready_o, ghr_o, count_o, mispredict_o);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_ni = 1'b0; en_i = 1'b0; lookup_valid_i = 1'b0; index_i = '0;
        fallback_i = 1'b0; resolve_valid_i = 1'b0; resolve_taken_i = 1'b0; flush_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state, then a miss with fallback taken at index 5.
        go(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        go(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation at hidx 5: lookup + correct taken resolve, then not-taken resolves.
        for (int i = 0; i < 3; i++) go(1'b1, 5 ^ m_ghr, 1'b0, 1'b1, head_pred(), 1'b0);
        for (int i = 0; i < 5; i++) go(1'b1, 5 ^ m_ghr, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) go(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Queue full, rejected fifth lookup, then resolve with a simultaneous lookup.
        for (int i = 0; i < 5; i++) go(1'b1, 20 + i, 1'b1, 1'b0, 1'b0, 1'b0);
        go(1'b1, 30, 1'b0, 1'b1, head_pred(), 1'b0);
        go(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mispredict on the head, then one idle cycle to see the pulse drop.
        go(1'b1, 40, 1'b0, 1'b1, ~head_pred(), 1'b0);
        go(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        go(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Empty resolve, then flush with two queued entries and a same-cycle resolve.
        go(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        go(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        go(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        go(1'b1, 11, 1'b1, 1'b1, head_pred(), 1'b1);
        go(1'b1, 7 ^ m_ghr, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable low with pending activity.
        step(1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1);

        // Randomized traffic over a small index range to force aliasing and bypass cases.
        for (int i = 0; i < 1500; i++) begin
            bit r_rst, r_en, r_lv, r_fb, r_rv, r_rt, r_fl;
            int r_idx;
            r_rst = ($urandom % 200) != 0;
            r_en  = ($urandom % 10) != 0;
            r_lv  = ($urandom % 10) < 6;
            r_idx = $urandom_range(0, 15);
            r_fb  = $urandom % 2;
            r_rv  = ($urandom % 10) < 5;
            r_rt  = (mq.size() > 0 && ($urandom % 4) != 0) ? mq[0].pred : 1'($urandom % 2);
            r_fl  = ($urandom % 40) == 0;
            step(r_rst, r_en, r_lv, r_idx, r_fb, r_rv, r_rt, r_fl);
        end

        go(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
